// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter and sequencer for a shared N-way mux resource. It
//   grants the resource to one requester at a time, drives the mux select
//   index, and holds the grant until the resource reports completion.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   i_req      request lines, bit k = requester k wants the resource
//   i_done     single-cycle completion pulse from the resource
//   o_grant    one-hot grant, zero when idle
//   o_select   binary index of the granted requester (holds when idle)
//   o_valid    resource owned (o_grant non-zero)
//   o_timeout  single-cycle pulse on forced release
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a grant held for MAX_HOLD cycles without i_done is
//   released as if i_done had arrived, and o_timeout pulses. When undefined,
//   no hold counter exists and o_timeout is tied low.
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no owner; first request seen wins on next edge
// BUSY  | grant held until i_done (or forced release)

module mux_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_HOLD = 16,
    localparam int SELECT_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic                   i_done,
    output logic [NUM_REQ-1:0]     o_grant,
    output logic [SELECT_BITS-1:0] o_select,
    output logic                   o_valid,
    output logic                   o_timeout
);

    generate
        if (NUM_REQ < 1) begin : g_bad_num_req
            $error("mux_rr_arbiter: NUM_REQ must be >= 1");
        end
        if (MAX_HOLD < 2) begin : g_bad_max_hold
            $error("mux_rr_arbiter: MAX_HOLD must be >= 2");
        end
    endgenerate

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [SELECT_BITS-1:0] select_q, select_d;
    logic                   valid_q, valid_d;
    logic [SELECT_BITS-1:0] last_q, last_d;
    logic [SELECT_BITS-1:0] win;
    logic                   found;
    logic                   tmo_hit;
    logic                   release_now;

    // Search starts just after the last winner and wraps, so the previous
    // owner is the last candidate considered.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && i_req[(int'(last_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = SELECT_BITS'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);

    logic [CNT_W-1:0] hold_q;
    logic             timeout_q;

    assign tmo_hit = (state_q == BUSY) && !i_done
                     && (hold_q == CNT_W'(MAX_HOLD - 1));

    // Counter never passes MAX_HOLD-1: reaching it forces a release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= tmo_hit;
            if (state_d == BUSY && (state_q == IDLE || release_now)) begin
                hold_q <= '0;
            end else if (state_q == BUSY && !release_now) begin
                hold_q <= hold_q + 1'b1;
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign release_now = (state_q == BUSY) && (i_done || tmo_hit);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        select_d = select_q;
        valid_d  = valid_q;
        last_d   = last_q;
        if (state_q == IDLE || release_now) begin
            if (found) begin
                grant_d      = '0;
                grant_d[win] = 1'b1;
                select_d     = win;
                valid_d      = 1'b1;
                last_d       = win;
                state_d      = BUSY;
            end else if (state_q == BUSY) begin
                // select_q deliberately holds its last value
                grant_d = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            select_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= SELECT_BITS'(NUM_REQ - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            select_q <= select_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign o_grant  = grant_q;
    assign o_select = select_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] i_req;
    logic         i_done;
    logic [N-1:0] o_grant;
    logic [1:0]   o_select;
    logic         o_valid;
    logic         o_timeout;

    int vectors = 0;
    int miscompares = 0;

    // reference model state: owner = -1 means nobody owns the resource
    int ref_owner;
    int ref_last;
    int ref_sel;
    int ref_hold;
    bit ref_tmo;

    mux_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_done    (i_done),
        .o_grant   (o_grant),
        .o_select  (o_select),
        .o_valid   (o_valid),
        .o_timeout (o_timeout)
    );

    always #5 clk = ~clk;

    function automatic int ref_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic ref_reset();
        ref_owner = -1;
        ref_last  = N - 1;
        ref_sel   = 0;
        ref_hold  = 0;
        ref_tmo   = 1'b0;
    endtask

    task automatic ref_clock(input logic [N-1:0] r, input logic d);
        bit do_arb;
        bit force_rel;
        int w;
        do_arb    = 1'b0;
        force_rel = 1'b0;
        ref_tmo   = 1'b0;
        if (ref_owner < 0) begin
            do_arb = 1'b1;
        end else begin
`ifdef ARB_TIMEOUT_EN
            force_rel = !d && (ref_hold == MH - 1);
`endif
            if (d || force_rel) begin
                ref_tmo = force_rel;
                do_arb  = 1'b1;
                ref_owner = -1;
            end else begin
                ref_hold++;
            end
        end
        if (do_arb) begin
            w = ref_pick(r, ref_last);
            if (w >= 0) begin
                ref_owner = w;
                ref_last  = w;
                ref_sel   = w;
                ref_hold  = 0;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [N-1:0] eg;
        eg = '0;
        if (ref_owner >= 0) eg[ref_owner] = 1'b1;
        vectors++;
        assert (o_grant === eg) else begin
            miscompares++;
            $error("FAIL %s grant observed=%b expected=%b", tag, o_grant, eg);
        end
        vectors++;
        assert (o_select === 2'(ref_sel)) else begin
            miscompares++;
            $error("FAIL %s select observed=%0d expected=%0d", tag, o_select, ref_sel);
        end
        vectors++;
        assert (o_valid === (ref_owner >= 0)) else begin
            miscompares++;
            $error("FAIL %s valid observed=%b expected=%b", tag, o_valid, ref_owner >= 0);
        end
        vectors++;
        assert (o_timeout === ref_tmo) else begin
            miscompares++;
            $error("FAIL %s timeout observed=%b expected=%b", tag, o_timeout, ref_tmo);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic d, input string tag);
        i_req  = r;
        i_done = d;
        @(posedge clk);
        ref_clock(r, d);
        #1;
        check(tag);
    endtask

    // reset asserted mid-cycle; outputs must clear without waiting for an edge
    task automatic pulse_reset(input logic [N-1:0] r, input string tag);
        i_req = r;
        #2;
        rst = 1'b1;
        #1;
        ref_reset();
        check(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        i_req  = '0;
        i_done = 1'b0;
        ref_reset();
        #7;
        check("reset_initial");
        @(negedge clk);
        rst = 1'b0;

        // first grant after reset goes to requester 0
        step(4'b1111, 1'b0, "first_grant");
        pulse_reset(4'b1111, "reset_mid_txn");
        step(4'b1111, 1'b0, "grant_after_reset");

        // single requester, held, then released to idle
        pulse_reset(4'b0000, "reset_single");
        step(4'b0100, 1'b0, "single_grant");
        for (int i = 0; i < 5; i++) step(4'b0100, 1'b0, "single_hold");
        step(4'b0000, 1'b1, "single_release");
        step(4'b0000, 1'b1, "idle_ignores_done");

        // fairness: done every third cycle, back-to-back grants 0,1,2,3,0
        pulse_reset(4'b0000, "reset_fair");
        for (int i = 0; i < 15; i++) step(4'b1111, (i % 3) == 2, "fairness");

        // wrap-around with requesters 0 and 3
        for (int i = 0; i < 6; i++) step(4'b1001, (i % 2) == 1, "wraparound");

        // withdrawal by the owner is ignored until done
        pulse_reset(4'b0000, "reset_withdraw");
        step(4'b0010, 1'b0, "withdraw_grant");
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, "withdraw_hold");
        step(4'b0000, 1'b1, "withdraw_release");

        // done and new request in the same cycle
        step(4'b0001, 1'b0, "simul_grant0");
        step(4'b0100, 1'b1, "simul_new_req");

        // hold with no done: forced release only with the timeout feature
        pulse_reset(4'b0000, "reset_timeout");
        step(4'b0011, 1'b0, "timeout_grant");
        for (int i = 0; i < MH; i++) step(4'b0011, 1'b0, "timeout_hold");
        step(4'b0011, 1'b0, "timeout_after");

        // randomized traffic
        pulse_reset(4'b0000, "reset_random");
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] r;
            logic d;
            r = N'($urandom_range(0, 15));
            d = ($urandom_range(0, 3) == 0);
            step(r, d, "random");
            if ($urandom_range(0, 99) == 0) pulse_reset(N'($urandom_range(0, 15)), "random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared N-way `mux` resource, such as a memory/bus port shared by fetch, load/store and similar requesters.
- Grants the resource to one requester at a time and drives the `mux` select index.
- Holds the grant until the resource signals transaction completion.
- Sits between requester request lines and the select input of the shared `mux` instance.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 1.
- SELECT_BITS, localparam = max(1, $clog2(NUM_REQ)), width of the select index; not overridable.
- MAX_HOLD, 16, maximum cycles a grant may be held before forced release; used only with ARB_TIMEOUT_EN; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- i_req  input  NUM_REQ  request lines; bit k = requester k wants the resource.
- i_done  input  1  single-cycle pulse from the resource: current transaction complete.
- o_grant  output  NUM_REQ  one-hot grant; all zeros when idle.
- o_select  output  SELECT_BITS  binary index of the granted requester; feeds `mux` i_select.
- o_valid  output  1  resource owned; high iff o_grant is non-zero.
- o_timeout  output  1  single-cycle pulse on forced release (see Optional Feature).

Behaviour:
- All outputs are registered. On rst (asynchronous):
  - o_grant=0, o_select=0, o_valid=0, o_timeout=0.
  - State=IDLE.
  - Last-winner pointer `last`=NUM_REQ-1, so requester 0 has first priority.
- Arbitration function:
  - Search i_req starting at index (last+1) mod NUM_REQ, ascending, wrapping past NUM_REQ-1 to 0.
  - The first set bit wins.
- State IDLE:
  - If i_req != 0, on the next edge: o_grant = onehot(winner), o_select = winner, o_valid=1, last = winner, state=BUSY.
  - Arbitration latency is 1 cycle from request to grant.
  - If i_req == 0, remain IDLE; outputs unchanged.
  - i_done in IDLE is ignored.
- State BUSY:
  - Grant held unchanged until i_done=1.
  - Deassertion of the granted requester's i_req while BUSY is ignored; the grant persists until i_done.
- On an edge with i_done=1 in BUSY:
  - If i_req != 0: re-arbitrate using the updated rotation and grant the new winner in the same edge (back-to-back, no idle cycle). The current owner is eligible again but has lowest priority.
  - If i_req == 0: o_grant=0, o_valid=0, state=IDLE.
- o_select when o_valid=0 holds its last value, never X; consumers must qualify with o_valid.
- NUM_REQ=1: requester 0 always wins; o_select is constantly 0.
- Simultaneous i_done and new request arrival in the same cycle: the new request participates in that cycle's arbitration.
- rst asserted mid-transaction: grant dropped immediately (asynchronous) and pointer reset; no completion is implied to the requester.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on every new grant and increments each BUSY cycle without i_done.
  - When the counter reaches MAX_HOLD-1 with i_done still low, the next edge behaves exactly as i_done=1 (re-arbitrate or go IDLE), and o_timeout pulses high for that one cycle.
  - Counter width is $clog2(MAX_HOLD).
- Not defined:
  - No counter is synthesized.
  - o_timeout is tied to 0.
  - A grant is held indefinitely until i_done.

Test Plan:
- Reset: assert rst with i_req=4'b1111 mid-cycle → all outputs 0 immediately. Release rst → first grant is 4'b0001, o_select=0, one cycle later.
- Single requester: i_req=4'b0100 at cycle 0 → cycle 1 o_grant=4'b0100, o_select=2, o_valid=1. Hold i_done=0 for 5 cycles → grant unchanged. i_done pulse with i_req=0 → o_valid=0 next edge.
- Fairness: i_req=4'b1111 constant, i_done pulsed every 3rd cycle → grant order 0,1,2,3,0, with no idle cycle between grants.
- Wrap-around: after requester 3 is served, i_req=4'b1001 with i_done → grant goes to 0. After the next i_done with i_req still 4'b1001 → grant 3.
- Request withdrawal: granted requester 1 drops i_req while BUSY → o_grant stays 4'b0010 until i_done.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): grant to 0, i_req=4'b0011, i_done never asserted → on the 16th cycle after the grant, o_timeout=1 for one cycle and o_grant=4'b0010. Without the macro → grant stays 4'b0001 and o_timeout stays 0.
